// File: rtl/stream_mux.sv
// stream_mux: N-to-1 valid/ready stream multiplexer with a single output register.
//
// The mux picks one input channel per cycle and loads that channel's word into
// the output register. A channel is picked in one of two ways:
//   - fixed mode: the channel given by sel;
//   - round-robin mode: the first valid channel at or above ptr, wrapping around.
// The output register accepts a new word whenever it is empty or is being
// drained in the same cycle, so the mux sustains one word per cycle.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous, active-high reset
//   in_valid   in   [N]        channel i offers a word
//   in_data    in   [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_ready   out  [N]        one-hot-or-zero accept for the granted channel
//   mode       in   0 = fixed select, 1 = round-robin
//   sel        in   [SEL_W]    channel index for fixed mode
//   out_valid  out  the output register holds a word
//   out_data   out  [WIDTH]    registered word
//   out_chan   out  [SEL_W]    channel that supplied out_data
//   out_ready  in   the sink takes the output word this cycle

module stream_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);

  // Channel vectors are padded to a power of two so that any sel / index
  // value addresses a real element; padded channels never offer data.
  localparam int NP = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic             load;

  logic [NP-1:0]    vld_pad;
  logic [WIDTH-1:0] ch_data [NP];

  logic             fix_ok;
  logic             fix_vld;

  logic [2*N-1:0]   vld_dbl;
  logic [N-1:0]     rot;
  logic             rr_found;
  logic [SEL_W-1:0] rr_off;
  logic [SEL_W:0]   rr_sum;
  logic [SEL_W-1:0] rr_idx;

  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer_in;
  logic [NP-1:0]    rdy_pad;

  assign load    = !rst && (!out_valid || out_ready);
  assign vld_pad = NP'(in_valid);

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_ch
      if (gi < N) begin : g_real
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign ch_data[gi] = '0;
      end
    end
  endgenerate

  // Fixed select: an out-of-range sel grants nothing.
  assign fix_ok  = ({1'b0, sel} < (SEL_W+1)'(N));
  assign fix_vld = fix_ok && vld_pad[sel];

  // Round-robin: rotate the valid vector so ptr lands on bit 0, then find the
  // lowest set bit; the channel is ptr plus that offset, modulo N.
  assign vld_dbl = {in_valid, in_valid};
  assign rot     = N'(vld_dbl >> ptr);

  always_comb begin
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_found = 1'b1;
        rr_off   = SEL_W'(k);
      end
    end
  end

  assign rr_sum = {1'b0, ptr} + {1'b0, rr_off};
  assign rr_idx = (rr_sum >= (SEL_W+1)'(N)) ? SEL_W'(rr_sum - (SEL_W+1)'(N))
                                            : SEL_W'(rr_sum);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode) begin
      gnt_vld = rr_found;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = fix_vld;
      gnt_idx = sel;
    end
  end

  assign xfer_in = load && gnt_vld;

  always_comb begin
    rdy_pad = '0;
    if (xfer_in) rdy_pad[gnt_idx] = 1'b1;
  end

  assign in_ready = rdy_pad[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= gnt_vld;
      // With no grant the register empties but keeps its last data/chan.
      if (gnt_vld) begin
        out_data <= ch_data[gnt_idx];
        out_chan <= gnt_idx;
      end
    end
  end

  // The round-robin pointer follows every accepted word, in either mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer_in) begin
      ptr <= (gnt_idx == SEL_W'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data bits per channel; legal values are 1 or more.
REQ-002 The module SHALL have parameter N, default 4, giving the number of input channels; legal values are 2 or more, and N is not required to be a power of two.
REQ-003 The module SHALL have derived localparam SEL_W = $clog2(N), giving the channel index width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port in_valid, input, N bits: bit i means channel i offers data.
REQ-007 The module SHALL have port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The module SHALL have port in_ready, output, N bits: bit i means channel i's data is accepted this cycle.
REQ-009 The module SHALL have port mode, input, 1 bit: 0 selects fixed select, 1 selects round-robin.
REQ-010 The module SHALL have port sel, input, SEL_W bits: the channel index used in fixed mode.
REQ-011 The module SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-012 The module SHALL have port out_data, output, WIDTH bits: the registered selected word.
REQ-013 The module SHALL have port out_chan, output, SEL_W bits: the index of the channel that supplied out_data.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the sink accepts the output word this cycle.

Function
REQ-015 A transfer on channel i SHALL occur in any cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur in any cycle where out_valid and out_ready are both 1.
REQ-016 Load enable SHALL be defined as load = !rst && (!out_valid || out_ready).
REQ-017 In fixed mode (mode=0), the grant SHALL be channel sel when sel < N and in_valid[sel] is 1; otherwise no channel SHALL be granted.
REQ-018 In round-robin mode (mode=1), the grant SHALL be the first channel with in_valid set, searching upward from the pointer ptr modulo N; if no channel is valid, no channel SHALL be granted.
REQ-019 in_ready SHALL be combinational and one-hot-or-zero, with in_ready[g] = load for the granted channel g and all other bits 0.
REQ-020 in_ready SHALL NOT depend on in_valid of any channel other than through the grant; channels not granted SHALL see ready 0.
REQ-021 On a load with a grant g, the next cycle SHALL have out_valid=1, out_data = channel g's data and out_chan = g; the latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-022 On a load with no grant, the next cycle SHALL have out_valid=0, with out_data and out_chan holding their previous values.
REQ-023 When out_valid=1 and out_ready=0, out_valid, out_data and out_chan SHALL hold and all in_ready bits SHALL be 0.
REQ-024 Simultaneous output and input transfers SHALL sustain a throughput of one word per cycle with no bubble.
REQ-025 On every input transfer from channel g, in either mode, ptr SHALL update to (g+1) mod N; when g = N-1, ptr SHALL wrap to 0.
REQ-026 ptr SHALL be unchanged in any cycle without an input transfer.
REQ-027 A change of mode or sel SHALL take effect in the same cycle's grant and SHALL NOT disturb a word already held in the output register.
REQ-028 No input word SHALL be dropped or duplicated: each input transfer SHALL produce exactly one output transfer, in acceptance order.

Reset
REQ-029 While rst=1, in_ready SHALL be all zeros and no transfer SHALL occur.
REQ-030 On a clock edge with rst=1, out_valid SHALL become 0, out_data SHALL become 0, out_chan SHALL become 0 and ptr SHALL become 0.
REQ-031 A reset asserted while out_valid=1 SHALL discard the held word, and the first cycle after reset release SHALL present in_ready according to REQ-019 with ptr=0.

Verification (N=4, WIDTH=8 unless stated)
REQ-032 Reset scenario: rst=1 for 2 cycles with in_valid=4'b1111 and out_ready=1 -> in_ready=0 throughout, then out_valid=0, out_data=0x00 and out_chan=0.
REQ-033 Fixed-select scenario: mode=0, sel=2, in_valid=4'b1111, data ch0..ch3 = 0xA0..0xA3, out_ready=1 -> in_ready=4'b0100, and the next cycle gives out_valid=1, out_data=0xA2, out_chan=2.
REQ-034 Round-robin scenario: mode=1, all channels valid, out_ready=1 for 5 cycles after reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-035 Backpressure scenario: with out_valid=1 and out_data=0x55, hold out_ready=0 for 3 cycles -> out_data stays 0x55 and in_ready=0; when out_ready=1, the next word loads in that same cycle.
REQ-036 Skip and wrap scenario: with ptr=1 and only ch3 and ch0 valid -> ch3 is granted, then ch0; ptr goes 0 then 1.
REQ-037 Out-of-range select scenario: N=3, mode=0, sel=3, all valid -> in_ready=3'b000 and out_valid drops to 0 after the held word drains.
